// File: rtl/jtcps1_obj_lbuf.sv
// Double-buffered object line buffer.
// While the draw engine fills one bank, the other bank is scanned out and
// cleared behind the read pointer so it is blank when it becomes the write
// bank again. After reset both banks are filled with all-ones before the
// buffer reports ready.
// Optional feature: define JTCPS1_OBJ_PRIO_EN to make the first opaque write
// to a word win. Without it, the last opaque write wins.
module jtcps1_obj_lbuf #(
    parameter int         DW     = 9,
    parameter int         AW     = 9,
    parameter logic [3:0] TRANSP = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          flip,
    input  logic          line_sel,
    input  logic [AW-1:0] hdump,
    input  logic          buf_wr,
    input  logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_data,
    output logic          ready,
    output logic [DW-1:0] pxl
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic          init_last;

    logic          line_r;
    logic          line_rr;
    logic          wbank;

    logic [AW-1:0] ra;
    logic          clr_pend;
    logic [AW-1:0] clr_addr;
    logic          clr_bank;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    logic [DW-1:0] rd_word;
    logic          wr_en;

    assign init_last = (cnt == {AW{1'b1}});
    assign ready     = (state == RUN);

    // Next-state logic: INIT lasts exactly one pass of the fill counter
    always_comb begin
        state_nx = state;
        if (state == INIT && init_last) begin
            state_nx = RUN;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Fill counter walks every address once during INIT, then holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == INIT && !init_last) begin
            cnt <= cnt + 1'b1;
        end
    end

    // line_sel copies keep tracking during INIT, so no spurious swap at RUN entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r  <= 1'b0;
            line_rr <= 1'b0;
        end else begin
            line_r  <= line_sel;
            line_rr <= line_r;
        end
    end

    // Bank swap one clk after the registered line parity changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
        end else if (state == RUN && line_r != line_rr) begin
            wbank <= ~wbank;
        end
    end

`ifdef JTCPS1_OBJ_PRIO_EN
    logic [DW-1:0] wr_cur;

    // Look up the target word so an opaque pixel already there is kept
    always_comb begin
        wr_cur = wbank ? mem_b[buf_addr] : mem_a[buf_addr];
        wr_en  = (state == RUN) && buf_wr && (buf_data[3:0] != TRANSP)
                 && (wr_cur[3:0] == TRANSP);
    end
`else
    // Every opaque pixel overwrites, so the last one drawn wins
    always_comb begin
        wr_en = (state == RUN) && buf_wr && (buf_data[3:0] != TRANSP);
    end
`endif

    // Read bank is always the one not being written
    always_comb begin
        rd_word = wbank ? mem_a[ra] : mem_b[ra];
    end

    // Read pipeline: capture the pixel, remember what to clear, sample next address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl      <= '1;
            ra       <= '0;
            clr_pend <= 1'b0;
            clr_addr <= '0;
            clr_bank <= 1'b0;
        end else begin
            clr_pend <= 1'b0;
            if (pxl_cen) begin
                ra <= flip ? ~hdump : hdump;
            end
            if (state == INIT) begin
                pxl <= '1;
            end else if (pxl_cen) begin
                pxl      <= rd_word;
                clr_pend <= 1'b1;
                clr_addr <= ra;
                clr_bank <= ~wbank;
            end
        end
    end

    // Bank A writes: fill during INIT, otherwise clear-after-read then draw (draw wins on overlap)
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem_a[cnt] <= '1;
        end else begin
            if (clr_pend && !clr_bank) begin
                mem_a[clr_addr] <= '1;
            end
            if (wr_en && !wbank) begin
                mem_a[buf_addr] <= buf_data;
            end
        end
    end

    // Bank B writes: same policy as bank A
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem_b[cnt] <= '1;
        end else begin
            if (clr_pend && clr_bank) begin
                mem_b[clr_addr] <= '1;
            end
            if (wr_en && wbank) begin
                mem_b[buf_addr] <= buf_data;
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_obj_lbuf.sv
// Self-checking bench for jtcps1_obj_lbuf (DW=9, AW=9, TRANSP=F).
// The reference model keeps both banks as plain arrays, swaps them on every
// line toggle, applies the write filter and clears each word as it is read.
module tb_jtcps1_obj_lbuf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       flip = 1'b0;
    logic       line_sel = 1'b0;
    logic [8:0] hdump = '0;
    logic       buf_wr = 1'b0;
    logic [8:0] buf_addr = '0;
    logic [8:0] buf_data = '0;
    logic       ready;
    logic [8:0] pxl;

    int n_checks = 0;
    int n_fail = 0;

    logic [8:0] mdl [2][512];
    int mwb;
    int prev_ra;

    jtcps1_obj_lbuf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .flip     (flip),
        .line_sel (line_sel),
        .hdump    (hdump),
        .buf_wr   (buf_wr),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .ready    (ready),
        .pxl      (pxl)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++)
                mdl[b][a] = 9'h1FF;
        mwb = 0;
        prev_ra = 0;
    endtask

    task automatic mdl_write(input int a, input logic [8:0] d);
        if (d[3:0] != 4'hF) begin
`ifdef JTCPS1_OBJ_PRIO_EN
            if (mdl[mwb][a][3:0] == 4'hF)
                mdl[mwb][a] = d;
`else
            mdl[mwb][a] = d;
`endif
        end
    endtask

    function automatic logic [8:0] rnd_pixel();
        logic [8:0] d;
        d = 9'($urandom);
        if ($urandom_range(3) == 0)
            d[3:0] = 4'hF;
        return d;
    endfunction

    // One-clk write; consecutive calls give back-to-back writes
    task automatic write_px(input int a, input logic [8:0] d);
        buf_wr   = 1'b1;
        buf_addr = a[8:0];
        buf_data = d;
        mdl_write(a, d);
        cyc();
        buf_wr = 1'b0;
    endtask

    // Toggle line parity, optionally with a write in the same clk
    task automatic toggle_line(input bit with_wr, input int a, input logic [8:0] d);
        line_sel = ~line_sel;
        if (with_wr) begin
            buf_wr   = 1'b1;
            buf_addr = a[8:0];
            buf_data = d;
            mdl_write(a, d);
        end
        mwb = 1 - mwb;
        cyc();
        buf_wr = 1'b0;
        repeat (4) cyc();
    endtask

    // One pxl_cen pulse followed by one idle clk; checks capture and hold
    task automatic do_read(input int h, input bit fl, input bit rnd_wr, input string name);
        int rb;
        int wa;
        logic [8:0] wd;
        logic [8:0] exp;
        rb = 1 - mwb;
        exp = mdl[rb][prev_ra];
        mdl[rb][prev_ra] = 9'h1FF;
        prev_ra = fl ? 511 - h : h;
        hdump = h[8:0];
        flip = fl;
        pxl_cen = 1'b1;
        if (rnd_wr && $urandom_range(1) == 1) begin
            wa = int'($urandom_range(511));
            wd = rnd_pixel();
            buf_wr = 1'b1;
            buf_addr = wa[8:0];
            buf_data = wd;
            mdl_write(wa, wd);
        end
        cyc();
        n_checks++;
        if (pxl !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s read hdump=%0d flip=%0d: got %h expected %h", name, h, fl, pxl, exp);
        end
        pxl_cen = 1'b0;
        buf_wr = 1'b0;
        cyc();
        n_checks++;
        if (pxl !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s hold hdump=%0d: got %h expected %h", name, h, pxl, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 600) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n < 511 || n > 513) begin
            n_fail++;
            $display("[TB] FAIL %s ready latency: got %0d clk expected 512", name, n);
        end
    endtask

    task automatic test_reset();
        mdl_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if (ready !== 1'b0 || pxl !== 9'h1FF) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got ready=%b pxl=%h expected ready=0 pxl=1ff", ready, pxl);
        end
        rst_n = 1'b1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL init_ready_low: got %b expected 0", ready);
        end
        wait_ready("reset_release");
        for (int h = 0; h < 512; h++)
            do_read(h, 1'b0, 1'b0, "reset_line");
    endtask

    task automatic test_basic();
        write_px(10, 9'h123);
        write_px(11, 9'h12F);
        toggle_line(1'b0, 0, '0);
        do_read(10, 1'b0, 1'b0, "basic");
        do_read(11, 1'b0, 1'b0, "basic_123");
        do_read(12, 1'b0, 1'b0, "basic_transp");
        toggle_line(1'b0, 0, '0);
        toggle_line(1'b0, 0, '0);
        do_read(10, 1'b0, 1'b0, "basic_clr");
        do_read(11, 1'b0, 1'b0, "basic_cleared");
        do_read(12, 1'b0, 1'b0, "basic_cleared2");
    endtask

    task automatic test_flip();
        write_px(0, 9'h045);
        toggle_line(1'b0, 0, '0);
        do_read(511, 1'b1, 1'b0, "flip");
        do_read(0, 1'b1, 1'b0, "flip_045");
        do_read(100, 1'b1, 1'b0, "flip_h0");
    endtask

    task automatic test_prio();
        write_px(5, 9'h011);
        write_px(5, 9'h022);
        toggle_line(1'b0, 0, '0);
        do_read(5, 1'b0, 1'b0, "prio");
        do_read(6, 1'b0, 1'b0, "prio_word");
    endtask

    task automatic test_toggle_edge();
        toggle_line(1'b1, 20, 9'h0A5);
        do_read(20, 1'b0, 1'b0, "edge");
        do_read(21, 1'b0, 1'b0, "edge_word");
        toggle_line(1'b0, 0, '0);
        do_read(20, 1'b0, 1'b0, "edge_next");
        do_read(21, 1'b0, 1'b0, "edge_next_word");
    endtask

    task automatic test_back_to_back();
        int base;
        for (int line = 0; line < 4; line++) begin
            base = (line == 0) ? 508 : int'($urandom_range(511));
            for (int i = 0; i < 12; i++)
                write_px((base + i) % 512, rnd_pixel());
            for (int i = 0; i < 40; i++)
                write_px(int'($urandom_range(511)), rnd_pixel());
            toggle_line(1'b0, 0, '0);
            for (int h = 0; h < 512; h++)
                do_read(h, line[0], 1'b1, "random");
        end
    endtask

    task automatic test_mid_reset();
        write_px(30, 9'h0A1);
        toggle_line(1'b0, 0, '0);
        do_read(30, 1'b0, 1'b0, "prereset");
        do_read(31, 1'b0, 1'b0, "prereset_word");
        for (int i = 0; i < 20; i++)
            write_px(int'($urandom_range(511)), rnd_pixel());
        toggle_line(1'b0, 0, '0);
        for (int i = 0; i < 6; i++)
            write_px(int'($urandom_range(511)), rnd_pixel());
        buf_wr = 1'b1;
        buf_addr = 9'd40;
        buf_data = 9'h066;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pxl !== 9'h1FF || ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_immediate: got ready=%b pxl=%h expected ready=0 pxl=1ff", ready, pxl);
        end
        mdl_reset();
        repeat (3) cyc();
        buf_wr = 1'b0;
        rst_n = 1'b1;
        wait_ready("mid_reset");
        for (int h = 0; h < 512; h++)
            do_read(h, 1'b0, 1'b0, "post_reset_b");
        toggle_line(1'b0, 0, '0);
        for (int h = 0; h < 512; h++)
            do_read(h, 1'b1, 1'b0, "post_reset_a");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flip();
        test_prio();
        test_toggle_edge();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
